dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 1024: data-memory size in bytes; valid word addresses are 0..ADDR_LIMIT-4.
REQ-002 Parameter STARVE_MAX, default 4: consecutive cycles the debug port may be denied before it is forced to win.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_req / cpu_we  in  1/1  CPU access request; write when cpu_we=1, else read.
REQ-006 cpu_addr / cpu_wdata  in  32/32  CPU byte address and write data.
REQ-007 cpu_gnt / cpu_rvalid / cpu_err  out  1/1/1  CPU grant, read-data-valid and address-error pulses.
REQ-008 cpu_rdata  out  32  CPU read data, valid only while cpu_rvalid=1.
REQ-009 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata: debug/loader port, same widths and meaning as the cpu_* ports.
REQ-010 mem_read / mem_write  out  1/1  one-cycle strobes to the data memory.
REQ-011 mem_addr / mem_wdata  out  32/32  memory address and write data.
REQ-012 mem_rdata  in  32  memory read data, registered by the memory, valid one cycle after mem_read.

Function
REQ-013 FSM states IDLE, CPU_RD, DBG_RD; reset state IDLE.
REQ-014 Grants are issued only in IDLE; gnt, mem_read and mem_write are combinational from the IDLE-state decision and last exactly one cycle.
REQ-015 Priority: CPU wins a simultaneous request unless the starvation count equals STARVE_MAX, in which case debug wins.
REQ-016 Starvation count increments (saturating at STARVE_MAX) each cycle dbg_req=1 and dbg is not granted, and clears when dbg is granted or dbg_req=0.
REQ-017 Granted write: mem_write=1 with mem_addr/mem_wdata from the winner; the FSM stays in IDLE; no rvalid is produced.
REQ-018 Granted read: mem_read=1; the FSM moves to CPU_RD or DBG_RD; the next cycle asserts the owner's rvalid with rdata=mem_rdata and returns to IDLE.
REQ-019 Read-to-read throughput is one access per 2 cycles; write-to-any throughput is one per cycle.
REQ-020 Requests are ignored while in CPU_RD or DBG_RD and are granted no earlier than the following IDLE cycle; requesters hold req and payload until gnt.
REQ-021 Address error: if addr[1:0]!=0 or addr>ADDR_LIMIT-4, the request is granted with err=1 and gnt=1 in the same cycle, with no mem strobe and no rvalid.
REQ-022 The non-owner port's rvalid, err and gnt are 0; its rdata is 0.
REQ-023 mem_addr and mem_wdata are 0 whenever no strobe is active.

Reset
REQ-024 While reset=1, all outputs are 0, the FSM is IDLE and the starvation count is 0, asynchronously.
REQ-025 Reset asserted in CPU_RD or DBG_RD discards the pending read; no rvalid follows deassertion.

Configuration
REQ-026 With DMEM_ARB_STATS_EN defined, the outputs cpu_gnt_cnt[15:0] and dbg_gnt_cnt[15:0] are added; each is a saturating count of grants, including error grants, and is cleared by reset.
REQ-027 Without DMEM_ARB_STATS_EN, those ports and counters do not exist and the rest of the behaviour is identical.

Structure
REQ-028 Package dmem_arb_pkg holds the FSM state enum, WORD_BYTES=4, and the address-check alignment mask.
REQ-029 Starvation logic is the sub-module dmem_arb_starve_ctr (inputs dbg_req, dbg_gnt; output force_dbg).

Verification
REQ-030 Write then read: CPU writes 0xDEADBEEF to address 0x10, then reads 0x10 -> cpu_rvalid one cycle after the read grant with cpu_rdata=0xDEADBEEF.
REQ-031 Simultaneous reads from both ports at addresses 0x0 and 0x4 -> CPU is granted first; debug is granted in the next IDLE cycle, 2 cycles later.
REQ-032 Starvation: cpu_req held high for writes and dbg_req high -> dbg_gnt is asserted after exactly 4 denied cycles; the CPU wins again afterwards.
REQ-033 Errors: addr 0x6 -> cpu_err=1 and no mem strobe; addr 0x3FC is accepted; addr 0x400 -> err=1.
REQ-034 Reset asserted in the cycle after a read grant -> no rvalid; the first request after reset is granted normally.
REQ-035 With DMEM_ARB_STATS_EN defined: 3 CPU grants and 2 debug grants -> cpu_gnt_cnt=3 and dbg_gnt_cnt=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCpuRd,
        StDbgRd
    } arb_state_e;

    // True when a byte address is misaligned or beyond the last valid word
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] addr_max);
        return ((addr & ALIGN_MASK) != 32'd0) || (addr > addr_max);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Debug-port starvation counter: raises force_dbg once debug has been
// denied STARVE_MAX consecutive cycles while requesting.
module dmem_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);
    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    // Saturating count of denied cycles; cleared by a grant or a dropped request
    always_comb begin
        w_cnt_d = r_cnt;
        if (!dbg_req || dbg_gnt) begin
            w_cnt_d = '0;
        end else if (r_cnt != CntMax) begin
            w_cnt_d = r_cnt + CntW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign force_dbg = (r_cnt == CntMax);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-port data memory with
// registered read data. Optional grant statistics: define DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] cpu_gnt_cnt,
    output logic [15:0] dbg_gnt_cnt
`endif
);
    localparam logic [31:0] AddrMax = 32'(ADDR_LIMIT - WORD_BYTES);

    arb_state_e  r_state;
    arb_state_e  w_state_d;
    logic        w_force_dbg;
    logic        w_idle;
    logic        w_cpu_win;
    logic        w_dbg_win;
    logic        w_any_win;
    logic        w_err;
    logic        w_win_we;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;

    dmem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .dbg_req  (dbg_req),
        .dbg_gnt  (dbg_gnt),
        .force_dbg(w_force_dbg)
    );

    // Arbitration decision; only taken in IDLE and never while reset is held
    always_comb begin
        w_idle      = (r_state == StIdle) && !reset;
        w_cpu_win   = w_idle && cpu_req && !(dbg_req && w_force_dbg);
        w_dbg_win   = w_idle && dbg_req && !w_cpu_win;
        w_any_win   = w_cpu_win || w_dbg_win;
        w_win_we    = w_dbg_win ? dbg_we    : cpu_we;
        w_win_addr  = w_dbg_win ? dbg_addr  : cpu_addr;
        w_win_wdata = w_dbg_win ? dbg_wdata : cpu_wdata;
        w_err       = w_any_win && addr_bad(w_win_addr, AddrMax);
    end

    // State register; reset discards any read in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state: a good read grant parks the FSM for one data-return cycle
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any_win && !w_err && !w_win_we) begin
                    w_state_d = w_cpu_win ? StCpuRd : StDbgRd;
                end
            end
            StCpuRd, StDbgRd: w_state_d = StIdle;
            default:          w_state_d = StIdle;
        endcase
    end

    // Outputs: grants/strobes from the IDLE decision, rvalid/rdata from read states
    always_comb begin
        cpu_gnt    = w_cpu_win;
        dbg_gnt    = w_dbg_win;
        cpu_err    = w_cpu_win && w_err;
        dbg_err    = w_dbg_win && w_err;
        mem_write  = w_any_win && !w_err && w_win_we;
        mem_read   = w_any_win && !w_err && !w_win_we;
        mem_addr   = (mem_write || mem_read) ? w_win_addr : 32'd0;
        mem_wdata  = mem_write ? w_win_wdata : 32'd0;
        cpu_rvalid = (r_state == StCpuRd) && !reset;
        dbg_rvalid = (r_state == StDbgRd) && !reset;
        cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : 32'd0;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cpu_cnt;
    logic [15:0] r_dbg_cnt;

    // Saturating grant counters, error grants included
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_cnt <= 16'd0;
            r_dbg_cnt <= 16'd0;
        end else begin
            if (cpu_gnt && (r_cpu_cnt != 16'hFFFF)) r_cpu_cnt <= r_cpu_cnt + 16'd1;
            if (dbg_gnt && (r_dbg_cnt != 16'hFFFF)) r_dbg_cnt <= r_dbg_cnt + 16'd1;
        end
    end

    assign cpu_gnt_cnt = r_cpu_cnt;
    assign dbg_gnt_cnt = r_dbg_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// traffic from both ports, checked every cycle against a transaction model.
// Define DMEM_ARB_STATS_EN to also exercise the grant counters.
module tb_dmem_arbiter;

    localparam int          SMAX   = 4;
    localparam logic [31:0] TB_MAX = 32'(1024 - 4);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_err   (dbg_err),
        .dbg_rdata (dbg_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .cpu_gnt_cnt(cpu_gnt_cnt),
        .dbg_gnt_cnt(dbg_gnt_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory attached to the DUT: registered read data
    bit [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [31:0] m_mem [256];
    int        m_owner = 0;      // 0: none, 1: cpu read pending, 2: dbg read pending
    logic [31:0] m_rd_data = 0;
    int        m_starve = 0;
    int        m_cpu_cnt = 0, m_dbg_cnt = 0;

    logic        e_cg, e_cv, e_ce, e_dg, e_dv, e_de, e_mr, e_mw;
    logic [31:0] e_cr, e_dr, e_ma, e_mwd;
    logic [199:0] e_vec, a_vec;

    always @(negedge clk) begin
        int          win;
        logic        we, bad;
        logic [31:0] a, d;
        {e_cg, e_cv, e_ce, e_dg, e_dv, e_de, e_mr, e_mw} = '0;
        {e_cr, e_dr, e_ma, e_mwd} = '0;
        win = 0;
        we = 0; a = 0; d = 0; bad = 0;
        if (!reset) begin
            if (m_owner == 1) begin
                e_cv = 1; e_cr = m_rd_data;
            end else if (m_owner == 2) begin
                e_dv = 1; e_dr = m_rd_data;
            end else begin
                if (cpu_req && dbg_req) win = (m_starve == SMAX) ? 2 : 1;
                else if (cpu_req)       win = 1;
                else if (dbg_req)       win = 2;
            end
            if (win != 0) begin
                we  = (win == 1) ? cpu_we    : dbg_we;
                a   = (win == 1) ? cpu_addr  : dbg_addr;
                d   = (win == 1) ? cpu_wdata : dbg_wdata;
                bad = (a % 4 != 0) || (a > TB_MAX);
                if (win == 1) begin e_cg = 1; e_ce = bad; end
                else          begin e_dg = 1; e_de = bad; end
                if (!bad) begin
                    e_ma = a;
                    if (we) begin e_mw = 1; e_mwd = d; end
                    else          e_mr = 1;
                end
            end
        end
        e_vec = {e_cg, e_cv, e_ce, e_cr, e_dg, e_dv, e_de, e_dr, e_mr, e_mw, e_ma, e_mwd};
        a_vec = {cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_err,
                 dbg_rdata, mem_read, mem_write, mem_addr, mem_wdata};
        tests++;
        if (a_vec !== e_vec) begin
            fails++;
            $display("FAIL outputs @cycle %0d: got %h, expected %h", cyc, a_vec, e_vec);
        end
`ifdef DMEM_ARB_STATS_EN
        chk("gnt_cnt", 64'({cpu_gnt_cnt, dbg_gnt_cnt}), 64'({m_cpu_cnt[15:0], m_dbg_cnt[15:0]}));
`endif
        // advance the model to the next cycle
        if (reset) begin
            m_owner = 0; m_starve = 0; m_cpu_cnt = 0; m_dbg_cnt = 0;
        end else begin
            if (m_owner != 0) m_owner = 0;
            else if (win != 0 && !bad) begin
                if (we) m_mem[a >> 2] = d;
                else begin m_owner = win; m_rd_data = m_mem[a >> 2]; end
            end
            if (win == 1 && m_cpu_cnt < 65535) m_cpu_cnt++;
            if (win == 2 && m_dbg_cnt < 65535) m_dbg_cnt++;
            if (dbg_req && win != 2) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            else                     m_starve = 0;
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request on a port, hold it until granted; returns wait cycles and err
    task automatic do_port(input bit is_dbg, input logic we, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic err);
        if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else        begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        lat = 0;
        err = 0;
        forever begin
            @(negedge clk);
            if (is_dbg ? dbg_gnt : cpu_gnt) begin
                err = is_dbg ? dbg_err : cpu_err;
                break;
            end
            lat++;
            if (lat > 20) begin
                chk(is_dbg ? "dbg_gnt_timeout" : "cpu_gnt_timeout", 64'(lat), 64'(20));
                break;
            end
        end
        @(posedge clk); #1;
        if (is_dbg) begin dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; end
        else        begin cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 11);
        case (r)
            0:       return 32'($urandom_range(0, 1023)) | 32'd1;
            1:       return 32'h400 + (32'($urandom_range(0, 15)) << 2);
            2:       return 32'hFFFF_FFFC;
            3, 4, 5: return 32'($urandom_range(0, 255)) << 2;
            default: return 32'($urandom_range(0, 7)) << 2;
        endcase
    endfunction

    task automatic random_port(input bit is_dbg, input int n);
        int   lat;
        logic err;
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            do_port(is_dbg, 1'($urandom_range(0, 1)), rand_addr(), $urandom, lat, err);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int   lat, lat2;
        int   cl [6];
        int   rv;
        logic err;

        // Reset with a request pending: nothing may come out
        cpu_req = 1;
        @(negedge clk);
        chk("gnt_in_reset", 64'({cpu_gnt, mem_read, mem_write}), 64'(0));
        step(); step();
        cpu_req = 0;
        reset = 0;
        step();

        // Write then read back
        do_port(0, 1, 32'h10, 32'hDEAD_BEEF, lat, err);
        chk("wr_lat", 64'(lat), 64'(0));
        do_port(0, 0, 32'h10, 32'h0, lat, err);
        @(negedge clk);
        chk("rd_rvalid", 64'(cpu_rvalid), 64'(1));
        chk("rd_data", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
        step();

        // Simultaneous reads: CPU first, debug two cycles later
        fork
            begin do_port(0, 0, 32'h0, 32'h0, lat, err); end
            begin do_port(1, 0, 32'h4, 32'h0, lat2, err); end
        join
        chk("simul_cpu_lat", 64'(lat), 64'(0));
        chk("simul_dbg_lat", 64'(lat2), 64'(2));
        step(); step();

        // Starvation: CPU streams writes, debug forced through after 4 denials
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    do_port(0, 1, 32'h100 + 32'(i * 4), 32'(i), cl[i], err);
                end
            end
            begin do_port(1, 1, 32'h200, 32'h5555_AAAA, lat2, err); end
        join
        chk("starve_dbg_lat", 64'(lat2), 64'(4));
        chk("starve_cpu_after", 64'({cl[3], cl[4], cl[5]}), 64'({32'd0, 32'd1, 32'd0}));
        step();

        // Address errors and the boundary word
        do_port(0, 0, 32'h6, 32'h0, lat, err);
        chk("err_0x6", 64'(err), 64'(1));
        do_port(0, 1, 32'h3FC, 32'h1234_5678, lat, err);
        chk("ok_0x3fc", 64'(err), 64'(0));
        do_port(1, 0, 32'h400, 32'h0, lat, err);
        chk("err_0x400", 64'(err), 64'(1));
        do_port(0, 0, 32'h3FC, 32'h0, lat, err);
        @(negedge clk);
        chk("rd_0x3fc", 64'(cpu_rdata), 64'(32'h1234_5678));
        step();

        // Reset in the cycle after a read grant discards the read
        do_port(0, 0, 32'h10, 32'h0, lat, err);
        reset = 1;
        step();
        reset = 0;
        rv = 0;
        repeat (3) begin
            @(negedge clk);
            rv += int'(cpu_rvalid) + int'(dbg_rvalid);
        end
        chk("rvalid_after_reset", 64'(rv), 64'(0));
        step();
        do_port(0, 0, 32'h10, 32'h0, lat, err);
        chk("post_reset_lat", 64'(lat), 64'(0));
        @(negedge clk);
        chk("post_reset_data", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));
        step();

`ifdef DMEM_ARB_STATS_EN
        reset = 1;
        step();
        reset = 0;
        do_port(0, 1, 32'h20, 32'h1, lat, err);
        do_port(0, 0, 32'h6, 32'h0, lat, err);
        do_port(0, 1, 32'h24, 32'h2, lat, err);
        do_port(1, 1, 32'h28, 32'h3, lat, err);
        do_port(1, 0, 32'h500, 32'h0, lat, err);
        chk("stats_cnt", 64'({cpu_gnt_cnt, dbg_gnt_cnt}), 64'({16'd3, 16'd2}));
`endif

        // Random traffic from both ports
        fork
            random_port(0, 200);
            random_port(1, 200);
        join
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
